inst_fifo: RTL and testbench

Dual-issue instruction queue between the fetch stage and the decode stage of the MIPS pipeline. Accepts up to two fetched instructions with their PCs per cycle and presents the two oldest entries to decode, first-word fall-through. Decode consumes zero, one or two per cycle. The instruction-name debug decoder taps `read_inst1`/`read_inst2` for waveform tracing. A pipeline flush (branch mispredict, exception, ERET) empties the queue in one cycle.

---
 rtl/inst_fifo_pkg.sv | 12 +
 rtl/inst_fifo_if.sv | 36 +++
 rtl/inst_fifo_ram.sv | 31 +++
 rtl/inst_fifo.sv | 85 ++++++++
 tb/tb_inst_fifo.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/inst_fifo_pkg.sv
// Shared widths, depth default and entry layout for the fetch-to-decode instruction queue.
// Field widths and depth are referenced by the queue, its storage and its interface.
package inst_fifo_pkg;
    localparam int INST_W          = 32;
    localparam int ADDR_W          = 32;
    localparam int INST_FIFO_DEPTH = 16;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
    } entry_t;
endpackage

// File: rtl/inst_fifo_if.sv
// Fetch/decode side bundle of the instruction queue: two write slots, two read slots, status.
// master = pipeline side driving requests; slave = the queue.
interface inst_fifo_if;
    import inst_fifo_pkg::*;

    logic              flush;
    logic              write_en1;
    logic              write_en2;
    logic [INST_W-1:0] write_inst1;
    logic [INST_W-1:0] write_inst2;
    logic [ADDR_W-1:0] write_addr1;
    logic [ADDR_W-1:0] write_addr2;
    logic              read_en1;
    logic              read_en2;
    logic [INST_W-1:0] read_inst1;
    logic [INST_W-1:0] read_inst2;
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] read_addr2;
    logic              empty;
    logic              almost_empty;
    logic              full;

    modport master (
        output flush, write_en1, write_en2, write_inst1, write_inst2,
               write_addr1, write_addr2, read_en1, read_en2,
        input  read_inst1, read_inst2, read_addr1, read_addr2,
               empty, almost_empty, full
    );

    modport slave (
        input  flush, write_en1, write_en2, write_inst1, write_inst2,
               write_addr1, write_addr2, read_en1, read_en2,
        output read_inst1, read_inst2, read_addr1, read_addr2,
               empty, almost_empty, full
    );
endinterface

// File: rtl/inst_fifo_ram.sv
// 2-write / 2-read register array: synchronous writes, asynchronous reads, storage not reset.
// Write latency 1 cycle; no flow control here, the caller gates the write enables.
module inst_fifo_ram
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = INST_FIFO_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we1,
    input  logic [PW-1:0] wa1,
    input  entry_t        wd1,
    input  logic          we2,
    input  logic [PW-1:0] wa2,
    input  entry_t        wd2,
    input  logic [PW-1:0] ra1,
    output entry_t        rd1,
    input  logic [PW-1:0] ra2,
    output entry_t        rd2
);
    entry_t mem [DEPTH];

    // wa1 and wa2 are always consecutive slots, so the two writes never collide.
    always_ff @(posedge clk) begin
        if (we1) mem[wa1] <= wd1;
        if (we2) mem[wa2] <= wd2;
    end

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
endmodule

// File: rtl/inst_fifo.sv
// Dual-issue fetch-to-decode instruction queue, first-word fall-through, one-cycle flush.
// Write visible 1 cycle later; writes blocked while fewer than two slots are free, reads clipped to count.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = INST_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       resetn,
    inst_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH - 2);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [1:0]    wcnt;
    logic [1:0]    rcnt;
    logic          empty;
    logic          almost_empty;
    logic          full;
    entry_t        wd1;
    entry_t        wd2;
    entry_t        rd1;
    entry_t        rd2;

    assign empty        = (count == '0);
    assign almost_empty = (count == CW'(1));
    assign full         = (count > FULL_LVL);

    always_comb begin
        wcnt = 2'd0;
        if (!full && bus.write_en1) wcnt = bus.write_en2 ? 2'd2 : 2'd1;
    end

    // Second pop only when a second entry actually exists.
    always_comb begin
        rcnt = 2'd0;
        if (bus.read_en1 && !empty) rcnt = (bus.read_en2 && !almost_empty) ? 2'd2 : 2'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(rcnt);
            tail  <= tail + PW'(wcnt);
            count <= count + CW'(wcnt) - CW'(rcnt);
        end
    end

    assign wd1 = '{inst: bus.write_inst1, addr: bus.write_addr1};
    assign wd2 = '{inst: bus.write_inst2, addr: bus.write_addr2};

    inst_fifo_ram #(.DEPTH(DEPTH), .PW(PW)) u_ram (
        .clk (clk),
        .we1 ((wcnt != 2'd0) && !bus.flush),
        .wa1 (tail),
        .wd1 (wd1),
        .we2 ((wcnt == 2'd2) && !bus.flush),
        .wa2 (tail + PW'(1)),
        .wd2 (wd2),
        .ra1 (head),
        .rd1 (rd1),
        .ra2 (head + PW'(1)),
        .rd2 (rd2)
    );

    // Absent entries read as zero so the debug decoder shows NOP.
    assign bus.read_inst1   = empty ? '0 : rd1.inst;
    assign bus.read_addr1   = empty ? '0 : rd1.addr;
    assign bus.read_inst2   = (empty || almost_empty) ? '0 : rd2.inst;
    assign bus.read_addr2   = (empty || almost_empty) ? '0 : rd2.addr;
    assign bus.empty        = empty;
    assign bus.almost_empty = almost_empty;
    assign bus.full         = full;
endmodule

// File: tb/tb_inst_fifo.sv
// Directed bench for inst_fifo: vector table plus fill, wrap-stream, flush and async-reset sequences.
module tb_inst_fifo;
    import inst_fifo_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    int   n_cmp = 0;
    int   n_bad = 0;

    inst_fifo_if bus ();

    inst_fifo #(.DEPTH(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we1, we2;
        logic [31:0] wi1, wa1, wi2, wa2;
        logic        re1, re2, fl;
        logic        e_empty, e_ae, e_full;
        logic [31:0] e_ri1, e_ra1, e_ri2, e_ra2;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we1, input logic we2,
                         input logic [31:0] wi1, input logic [31:0] wa1,
                         input logic [31:0] wi2, input logic [31:0] wa2,
                         input logic re1, input logic re2, input logic fl);
        bus.write_en1   = we1;
        bus.write_en2   = we2;
        bus.write_inst1 = wi1;
        bus.write_addr1 = wa1;
        bus.write_inst2 = wi2;
        bus.write_addr2 = wa2;
        bus.read_en1    = re1;
        bus.read_en2    = re2;
        bus.flush       = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string nm, input logic e, input logic ae, input logic f);
        chk({nm, ".empty"},        32'(bus.empty),        32'(e));
        chk({nm, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
        chk({nm, ".full"},         32'(bus.full),         32'(f));
    endtask

    initial begin
        int mcount, w, r, wacc, racc, wr_pc, rd_pc, written, nread, k;

        idle();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk_flags("reset", 1'b1, 1'b0, 1'b0);
        chk("reset.read_inst1", bus.read_inst1, 32'h0);
        chk("reset.read_addr2", bus.read_addr2, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // {we1,we2,wi1,wa1,wi2,wa2,re1,re2,fl, empty,ae,full, ri1,ra1,ri2,ra2}
        vecs[0] = '{1'b0, 1'b1, 32'hDEADBEEF, 32'h11110000, 32'hCAFEF00D, 32'h22220000, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b0, 32'h24020002, 32'hBFC00004, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000000C, 32'h00000100, 32'h0000000D, 32'h00000104, 1'b1, 1'b1, 1'b0,
                    1'b0, 1'b0, 1'b0, 32'h0000000C, 32'h00000100, 32'h0000000D, 32'h00000104};
        vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h0000000E, 32'h00000200, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b0, 32'h0000000E, 32'h00000200, 32'h0, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].we1, vecs[i].we2, vecs[i].wi1, vecs[i].wa1, vecs[i].wi2, vecs[i].wa2,
                  vecs[i].re1, vecs[i].re2, vecs[i].fl);
            step();
            chk_flags($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_ae, vecs[i].e_full);
            chk($sformatf("vec%0d.read_inst1", i), bus.read_inst1, vecs[i].e_ri1);
            chk($sformatf("vec%0d.read_addr1", i), bus.read_addr1, vecs[i].e_ra1);
            chk($sformatf("vec%0d.read_inst2", i), bus.read_inst2, vecs[i].e_ri2);
            chk($sformatf("vec%0d.read_addr2", i), bus.read_addr2, vecs[i].e_ra2);
        end

        // Fill to 15 entries with single writes; full only at 15.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h1000 + i, 32'h8000 + 4 * i, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            step();
            chk($sformatf("fill%0d.full", i), 32'(bus.full), 32'(i == 14));
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hF0F0F0F0, 32'h9000, 32'hE0E0E0E0, 32'h9004, 1'b0, 1'b0, 1'b0);
        step();
        chk("fullwr.full", 32'(bus.full), 32'h1);
        chk("fullwr.read_inst1", bus.read_inst1, 32'h1000);
        @(negedge clk);
        idle();
        step();
        chk("fullidle.full", 32'(bus.full), 32'h1);

        // Drain two at a time; exactly 15 entries must come out in order, across the wrap.
        k = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
            #1;
            chk($sformatf("drain%0d.read_inst1", k), bus.read_inst1, 32'h1000 + k);
            chk($sformatf("drain%0d.read_inst2", k), bus.read_inst2, (k < 14) ? 32'h1001 + k : 32'h0);
            step();
            k = (k + 2 > 15) ? 15 : k + 2;
        end
        chk("drain.empty", 32'(bus.empty), 32'h1);

        // Stream 40 sequential PCs with mixed widths; decode must see them in order.
        mcount = 0; written = 0; nread = 0;
        wr_pc = 32'h00400000; rd_pc = 32'h00400000;
        for (int cyc = 0; cyc < 300 && nread < 40; cyc++) begin
            @(negedge clk);
            w = (written >= 40) ? 0 : (cyc % 3 == 0) ? 2 : (cyc % 3 == 1) ? 1 : 0;
            if (w == 2 && written == 39) w = 1;
            r = (cyc % 4 == 0) ? 0 : (cyc % 4 == 3) ? 1 : 2;
            drive(w > 0, w == 2, wr_pc ^ 32'hA5A50000, wr_pc, (wr_pc + 4) ^ 32'hA5A50000, wr_pc + 4,
                  r > 0, r == 2, 1'b0);
            #1;
            chk($sformatf("stream%0d.empty", cyc), 32'(bus.empty), 32'(mcount == 0));
            if (mcount >= 1) chk($sformatf("stream%0d.read_addr1", cyc), bus.read_addr1, rd_pc);
            chk($sformatf("stream%0d.read_addr2", cyc), bus.read_addr2, (mcount >= 2) ? rd_pc + 4 : 32'h0);
            wacc = (mcount > 14) ? 0 : w;
            racc = (r > mcount) ? mcount : r;
            @(posedge clk);
            mcount  = mcount + wacc - racc;
            written = written + wacc;
            wr_pc   = wr_pc + 4 * wacc;
            rd_pc   = rd_pc + 4 * racc;
            nread   = nread + racc;
        end
        chk("stream.pcs_read", nread, 32'd40);
        #1;
        chk("stream.empty", 32'(bus.empty), 32'h1);

        // Build count=5, then flush together with a dual write and dual read.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h3000, 32'h300, 32'h3001, 32'h304, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h3002, 32'h308, 32'h3003, 32'h30C, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h3004, 32'h310, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("pre_flush.read_inst1", bus.read_inst1, 32'h3000);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h3005, 32'h314, 32'h3006, 32'h318, 1'b1, 1'b1, 1'b1);
        step();
        chk_flags("flush", 1'b1, 1'b0, 1'b0);
        chk("flush.read_inst1", bus.read_inst1, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h4444, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk_flags("post_flush", 1'b0, 1'b1, 1'b0);
        chk("post_flush.read_inst1", bus.read_inst1, 32'h4444);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h5555, 32'h50, 32'h5556, 32'h54, 1'b0, 1'b0, 1'b0);
        step();
        chk("pre_rst.empty", 32'(bus.empty), 32'h0);
        @(negedge clk);
        idle();
        #2 resetn = 1'b0;
        #1;
        chk_flags("async_rst", 1'b1, 1'b0, 1'b0);
        chk("async_rst.read_inst1", bus.read_inst1, 32'h0);
        chk("async_rst.read_addr1", bus.read_addr1, 32'h0);
        chk("async_rst.read_inst2", bus.read_inst2, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
